// File: rtl/usb_pkg.sv
// Shared USB definitions: transmit buffer sizing and the byte type.
package usb_pkg;
  localparam int TX_BUF_DEPTH = 64;
  localparam int TX_BUF_CNT_W = $clog2(TX_BUF_DEPTH) + 1;

  typedef logic [7:0] usb_byte_t;
endpackage

// File: rtl/tx_data_buffer_if.sv
// Host push / transmitter pop bundle of the transmit data buffer.
interface tx_data_buffer_if
  import usb_pkg::*;
#(
  parameter int CNT_W = TX_BUF_CNT_W
);
  logic             store_tx_data;
  usb_byte_t        tx_data;
  logic             get_tx_packet_data;
  logic             clear;
  usb_byte_t        tx_packet_data;
  logic [CNT_W-1:0] tx_packet_data_size;
  logic             buffer_full;
  logic             buffer_empty;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output store_tx_data, tx_data, get_tx_packet_data, clear,
    input  tx_packet_data, tx_packet_data_size, buffer_full, buffer_empty,
           overflow_err, underflow_err
  );

  modport slave (
    input  store_tx_data, tx_data, get_tx_packet_data, clear,
    output tx_packet_data, tx_packet_data_size, buffer_full, buffer_empty,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/tx_data_buffer_ptr.sv
// Wrap-bit pointer: counts modulo 2^W, synchronous clear.
module fifo_ptr #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk) begin
    if (clr)     ptr <= '0;
    else if (en) ptr <= ptr + W'(1);
  end
endmodule

// File: rtl/tx_data_buffer.sv
// First-word-fall-through byte FIFO between host and USB transmitter,
// with flush and sticky overflow/underflow flags.
module tx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = TX_BUF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  tx_data_buffer_if.slave   bus
);
  localparam int AW = CNT_W - 1;

  usb_byte_t        mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;
  logic             push_ok, pop_ok;
  logic             ptr_clr;
  logic             overflow_q, underflow_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop frees a slot this cycle, so a push into a full buffer still lands.
  assign pop_ok  = bus.get_tx_packet_data && !empty;
  assign push_ok = bus.store_tx_data && (!full || pop_ok);
  assign ptr_clr = rst || bus.clear;

  fifo_ptr #(.W(CNT_W)) u_wr_ptr (
    .clk (clk),
    .clr (ptr_clr),
    .en  (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.W(CNT_W)) u_rd_ptr (
    .clk (clk),
    .clr (ptr_clr),
    .en  (pop_ok),
    .ptr (rd_ptr)
  );

  // Storage is left unreset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (!ptr_clr && push_ok) mem[wr_ptr[AW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (ptr_clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.store_tx_data && !push_ok)   overflow_q  <= 1'b1;
      if (bus.get_tx_packet_data && !pop_ok) underflow_q <= 1'b1;
    end
  end

  assign bus.tx_packet_data      = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign bus.tx_packet_data_size = wr_ptr - rd_ptr;
  assign bus.buffer_full         = full;
  assign bus.buffer_empty        = empty;
  assign bus.overflow_err        = overflow_q;
  assign bus.underflow_err       = underflow_q;
endmodule

// File: tb/tb_tx_data_buffer.sv
// Directed self-checking bench for tx_data_buffer.
module tb_tx_data_buffer;
  import usb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  tx_data_buffer_if bus ();

  tx_data_buffer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.store_tx_data      = 1'b0;
    bus.get_tx_packet_data = 1'b0;
    bus.clear              = 1'b0;
    bus.tx_data            = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.tx_packet_data !== 8'h00) $display("FAIL reset_data got %h exp 00", bus.tx_packet_data); else passed++;
    total++; if (bus.tx_packet_data_size !== 7'd0) $display("FAIL reset_size got %0d exp 0", bus.tx_packet_data_size); else passed++;
    total++; if (bus.buffer_empty !== 1'b1 || bus.buffer_full !== 1'b0)
      $display("FAIL reset_flags got empty=%b full=%b exp 1/0", bus.buffer_empty, bus.buffer_full); else passed++;
    total++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0)
      $display("FAIL reset_errs got ovf=%b udf=%b exp 0/0", bus.overflow_err, bus.underflow_err); else passed++;
  endtask

  task automatic test_push3();
    usb_byte_t b [3] = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      bus.store_tx_data = 1'b1;
      bus.tx_data       = b[i];
      tick();
      total++; if (bus.tx_packet_data_size !== 7'(i + 1))
        $display("FAIL push3_size[%0d] got %0d exp %0d", i, bus.tx_packet_data_size, i + 1); else passed++;
      total++; if (bus.tx_packet_data !== 8'hA1)
        $display("FAIL push3_head[%0d] got %h exp a1", i, bus.tx_packet_data); else passed++;
      total++; if (bus.buffer_empty !== 1'b0)
        $display("FAIL push3_empty[%0d] got %b exp 0", i, bus.buffer_empty); else passed++;
    end
    idle();
  endtask

  task automatic test_pop3();
    usb_byte_t nxt [3] = '{8'hB2, 8'hC3, 8'h00};
    for (int i = 0; i < 3; i++) begin
      bus.get_tx_packet_data = 1'b1;
      tick();
      total++; if (bus.tx_packet_data !== nxt[i])
        $display("FAIL pop3_data[%0d] got %h exp %h", i, bus.tx_packet_data, nxt[i]); else passed++;
      total++; if (bus.tx_packet_data_size !== 7'(2 - i))
        $display("FAIL pop3_size[%0d] got %0d exp %0d", i, bus.tx_packet_data_size, 2 - i); else passed++;
    end
    idle();
    total++; if (bus.buffer_empty !== 1'b1) $display("FAIL pop3_empty got %b exp 1", bus.buffer_empty); else passed++;
    total++; if (bus.underflow_err !== 1'b0) $display("FAIL pop3_udf got %b exp 0", bus.underflow_err); else passed++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 64; i++) begin
      bus.store_tx_data = 1'b1;
      bus.tx_data       = 8'(i);
      tick();
    end
    idle();
    total++; if (bus.buffer_full !== 1'b1) $display("FAIL fill_full got %b exp 1", bus.buffer_full); else passed++;
    total++; if (bus.tx_packet_data_size !== 7'd64) $display("FAIL fill_size got %0d exp 64", bus.tx_packet_data_size); else passed++;
    bus.store_tx_data = 1'b1;
    bus.tx_data       = 8'hFF;
    tick();
    idle();
    total++; if (bus.overflow_err !== 1'b1) $display("FAIL ovf_flag got %b exp 1", bus.overflow_err); else passed++;
    total++; if (bus.tx_packet_data_size !== 7'd64) $display("FAIL ovf_size got %0d exp 64", bus.tx_packet_data_size); else passed++;
    for (int i = 0; i < 64; i++) begin
      total++; if (bus.tx_packet_data !== 8'(i))
        $display("FAIL drain_data[%0d] got %h exp %h", i, bus.tx_packet_data, 8'(i)); else passed++;
      bus.get_tx_packet_data = 1'b1;
      tick();
    end
    idle();
    total++; if (bus.buffer_empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", bus.buffer_empty); else passed++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 64; i++) begin
      bus.store_tx_data = 1'b1;
      bus.tx_data       = 8'(8'h80 + i);
      tick();
    end
    bus.tx_data            = 8'h55;
    bus.get_tx_packet_data = 1'b1;
    tick();
    idle();
    total++; if (bus.tx_packet_data_size !== 7'd64) $display("FAIL fullpp_size got %0d exp 64", bus.tx_packet_data_size); else passed++;
    total++; if (bus.buffer_full !== 1'b1) $display("FAIL fullpp_full got %b exp 1", bus.buffer_full); else passed++;
    // Head popped was 0x80; remaining order is 0x81..0xBF then 0x55.
    for (int i = 0; i < 64; i++) begin
      usb_byte_t exp_b;
      exp_b = (i == 63) ? 8'h55 : 8'(8'h81 + i);
      total++; if (bus.tx_packet_data !== exp_b)
        $display("FAIL fullpp_drain[%0d] got %h exp %h", i, bus.tx_packet_data, exp_b); else passed++;
      bus.get_tx_packet_data = 1'b1;
      tick();
    end
    idle();
    total++; if (bus.buffer_empty !== 1'b1) $display("FAIL fullpp_empty got %b exp 1", bus.buffer_empty); else passed++;
  endtask

  task automatic test_underflow_clear();
    bus.get_tx_packet_data = 1'b1;
    tick();
    idle();
    total++; if (bus.underflow_err !== 1'b1) $display("FAIL udf_flag got %b exp 1", bus.underflow_err); else passed++;
    total++; if (bus.tx_packet_data_size !== 7'd0) $display("FAIL udf_size got %0d exp 0", bus.tx_packet_data_size); else passed++;
    bus.clear         = 1'b1;
    bus.store_tx_data = 1'b1;
    bus.tx_data       = 8'h99;
    tick();
    idle();
    total++; if (bus.tx_packet_data_size !== 7'd0) $display("FAIL clr_size got %0d exp 0", bus.tx_packet_data_size); else passed++;
    total++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0)
      $display("FAIL clr_errs got ovf=%b udf=%b exp 0/0", bus.overflow_err, bus.underflow_err); else passed++;
    total++; if (bus.buffer_empty !== 1'b1 || bus.tx_packet_data !== 8'h00)
      $display("FAIL clr_empty got empty=%b data=%h exp 1/00", bus.buffer_empty, bus.tx_packet_data); else passed++;
  endtask

  task automatic test_wrap_reset();
    bus.store_tx_data = 1'b1;
    bus.tx_data       = 8'h00;
    tick();
    // Steady one-deep stream: 200 pushes drive both pointers past the wrap bit.
    for (int k = 1; k < 200; k++) begin
      total++; if (bus.tx_packet_data !== 8'(k - 1))
        $display("FAIL wrap_data[%0d] got %h exp %h", k, bus.tx_packet_data, 8'(k - 1)); else passed++;
      bus.store_tx_data      = 1'b1;
      bus.get_tx_packet_data = 1'b1;
      bus.tx_data            = 8'(k);
      tick();
      total++; if (bus.tx_packet_data_size !== 7'd1)
        $display("FAIL wrap_size[%0d] got %0d exp 1", k, bus.tx_packet_data_size); else passed++;
    end
    idle();
    bus.get_tx_packet_data = 1'b1;
    tick();
    idle();
    total++; if (bus.buffer_empty !== 1'b1 || bus.underflow_err !== 1'b0)
      $display("FAIL wrap_empty got empty=%b udf=%b exp 1/0", bus.buffer_empty, bus.underflow_err); else passed++;
    bus.store_tx_data = 1'b1;
    bus.tx_data       = 8'h7E;
    tick();
    idle();
    total++; if (bus.tx_packet_data !== 8'h7E || bus.tx_packet_data_size !== 7'd1)
      $display("FAIL wrap_push got data=%h size=%0d exp 7e/1", bus.tx_packet_data, bus.tx_packet_data_size); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.tx_packet_data_size !== 7'd0) $display("FAIL rst_size got %0d exp 0", bus.tx_packet_data_size); else passed++;
    total++; if (bus.tx_packet_data !== 8'h00) $display("FAIL rst_data got %h exp 00", bus.tx_packet_data); else passed++;
    total++; if (bus.buffer_empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", bus.buffer_empty); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_push3();
    test_pop3();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow_clear();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
